// File: rtl/sample_window.sv
// Sample buffer and 4-tap window feeder for the moving-average filter.
// Bursty input is queued in a FIFO and released one sample per tick.
module sample_window #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 100
) (
    input  logic                            CLK100MHZ,
    input  logic                            reset_n,
    input  logic signed [DATA_W-1:0]        in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic signed [DATA_W-1:0]        current,
    output logic signed [DATA_W-1:0]        delay,
    output logic signed [DATA_W-1:0]        delay2,
    output logic signed [DATA_W-1:0]        delay3,
    output logic                            start,
    output logic                            primed,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [TW-1:0]     tick_cnt;
    logic [1:0]        fill_cnt;
    logic [0:0]        state;
    logic              tick;
    logic              push;
    logic              pop;

    assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
    // Registered count only: a full FIFO refuses even if a pop happens now.
    assign in_ready = (fifo_count < CW'(FIFO_DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = tick && (fifo_count != '0);

    always_ff @(posedge CLK100MHZ) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n)
            tick_cnt <= '0;
        else if (flush || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            current  <= '0;
            delay    <= '0;
            delay2   <= '0;
            delay3   <= '0;
            start    <= 1'b0;
            primed   <= 1'b0;
            fill_cnt <= '0;
            state    <= FILL;
        end else if (flush) begin
            current  <= '0;
            delay    <= '0;
            delay2   <= '0;
            delay3   <= '0;
            start    <= 1'b0;
            primed   <= 1'b0;
            fill_cnt <= '0;
            state    <= FILL;
        end else if (pop) begin
            current <= mem[rd_ptr];
            delay   <= current;
            delay2  <= delay;
            delay3  <= delay2;
            unique case (state)
                FILL: begin
                    // Fourth shift completes the first window.
                    if (fill_cnt == 2'd3) begin
                        state    <= RUN;
                        primed   <= 1'b1;
                        start    <= 1'b1;
                        fill_cnt <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                        start    <= 1'b0;
                    end
                end
                RUN: start <= 1'b1;
                default: start <= 1'b0;
            endcase
        end else begin
            start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sample_window.sv
// Randomized and directed bench for sample_window with a queue-based
// reference model and a start-strobe scoreboard.
module tb_sample_window;

    localparam int DEPTH = 8;
    localparam int TD    = 4;

    logic              CLK100MHZ = 1'b0;
    logic              reset_n   = 1'b0;
    logic signed [7:0] in_data   = '0;
    logic              in_valid  = 1'b0;
    logic              flush     = 1'b0;
    logic              in_ready;
    logic signed [7:0] current;
    logic signed [7:0] delay;
    logic signed [7:0] delay2;
    logic signed [7:0] delay3;
    logic              start;
    logic              primed;
    logic [3:0]        fifo_count;

    sample_window #(
        .DATA_W(8),
        .FIFO_DEPTH(DEPTH),
        .TICK_DIV(TD)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .reset_n(reset_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .current(current),
        .delay(delay),
        .delay2(delay2),
        .delay3(delay3),
        .start(start),
        .primed(primed),
        .fifo_count(fifo_count)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    bit saw_full = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the accepted samples form a queue; every tick
    // takes the oldest one into a 4-entry window (win[0] newest).
    logic [7:0]  mq[$];
    logic [7:0]  win[4];
    logic [31:0] exp_q[$];
    bit          m_primed;
    int          nshift;
    int          cyc;
    bit          m_tick;
    bit          m_rdy;

    always @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            exp_q.delete();
            win      = '{default: '0};
            m_primed = 1'b0;
            nshift   = 0;
            cyc      = 0;
        end else if (flush) begin
            mq.delete();
            win      = '{default: '0};
            m_primed = 1'b0;
            nshift   = 0;
            cyc      = 0;
        end else begin
            m_tick = (cyc % TD) == (TD - 1);
            m_rdy  = mq.size() < DEPTH;
            if (m_tick && mq.size() > 0) begin
                win[3] = win[2];
                win[2] = win[1];
                win[1] = win[0];
                win[0] = mq.pop_front();
                nshift++;
                if (nshift >= 4) begin
                    m_primed = 1'b1;
                    exp_q.push_back({win[0], win[1], win[2], win[3]});
                end
            end
            if (in_valid && m_rdy)
                mq.push_back(in_data);
            cyc++;
        end
    end

    // Monitor: per-cycle state compare plus scoreboard on each start.
    always @(negedge CLK100MHZ) begin
        if (reset_n) begin
            chk("fifo_count", fifo_count, mq.size());
            chk("in_ready", in_ready, (mq.size() < DEPTH) && !flush);
            chk("primed", primed, m_primed);
            chk("taps", {current, delay, delay2, delay3},
                {win[0], win[1], win[2], win[3]});
            if (fifo_count == 4'(DEPTH) && !in_ready)
                saw_full = 1'b1;
            if (start) begin
                n_start++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got 1 expected 0 at %0t", $time);
                end else begin
                    chk("window", {current, delay, delay2, delay3},
                        exp_q.pop_front());
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missed_start: got 0 expected 1 at %0t", $time);
                exp_q.delete();
            end
        end
    end

    // Drivers: each call starts and ends at negedge+1.
    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) begin
            @(negedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        flush    = 1'b0;
        @(negedge CLK100MHZ);
        #1;
    endtask

    task automatic push_hold(input logic [7:0] v);
        bit r;
        int n;
        in_valid = 1'b1;
        in_data  = v;
        flush    = 1'b0;
        n = 0;
        forever begin
            #3 r = in_ready;
            @(negedge CLK100MHZ);
            #1;
            if (r)
                break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: got stalled expected accept");
                break;
            end
        end
    endtask

    int base;
    int rate;

    initial begin
        repeat (3) @(negedge CLK100MHZ);
        #1;
        chk("rst_taps", {current, delay, delay2, delay3}, 0);
        chk("rst_start", start, 0);
        chk("rst_primed", primed, 0);
        chk("rst_count", fifo_count, 0);
        reset_n = 1'b1;
        #3 chk("rst_ready", in_ready, 1);
        @(negedge CLK100MHZ);
        #1;

        // First window
        push(8'd10);
        push(8'd20);
        push(8'd30);
        push(8'd40);
        idle(20);
        chk("first_starts", n_start, 1);
        chk("first_primed", primed, 1);
        chk("first_window", {current, delay, delay2, delay3}, 32'h281E140A);

        // Negative sample
        push(8'hFB);
        idle(8);
        chk("neg_starts", n_start, 2);
        chk("neg_window", {current, delay, delay2, delay3}, 32'hFB281E14);

        // Backpressure and order
        for (int i = 1; i <= 14; i++)
            push_hold(8'(i));
        idle(64);
        chk("bp_full_seen", saw_full, 1);
        chk("bp_starts", n_start, 16);
        chk("bp_window", {current, delay, delay2, delay3}, 32'h0E0D0C0B);

        // Underrun
        idle(12);
        chk("ur_starts", n_start, 16);
        chk("ur_window", {current, delay, delay2, delay3}, 32'h0E0D0C0B);
        chk("ur_primed", primed, 1);

        // Flush mid-run
        push(8'd7);
        push(8'd8);
        push(8'd9);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        #3 chk("flush_ready", in_ready, 0);
        @(negedge CLK100MHZ);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", fifo_count, 0);
        chk("flush_taps", {current, delay, delay2, delay3}, 0);
        chk("flush_primed", primed, 0);
        base = n_start;
        push(8'd50);
        push(8'd51);
        push(8'd52);
        idle(20);
        chk("flush_3_starts", n_start - base, 0);
        push(8'd53);
        idle(8);
        chk("flush_4_starts", n_start - base, 1);
        chk("flush_window", {current, delay, delay2, delay3}, 32'h35343332);

        // Async reset between edges
        chk("pre_rst_primed", primed, 1);
        push(8'd5);
        push(8'd6);
        in_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_taps", {current, delay, delay2, delay3}, 0);
        chk("arst_start", start, 0);
        chk("arst_primed", primed, 0);
        chk("arst_count", fifo_count, 0);
        @(negedge CLK100MHZ);
        #1;
        reset_n = 1'b1;

        // Randomized traffic with varying burst density
        for (int seg = 0; seg < 4; seg++) begin
            rate = (seg == 0) ? 90 : (seg == 1) ? 10 : (seg == 2) ? 50 : 30;
            for (int c = 0; c < 100; c++) begin
                in_valid = ($urandom_range(0, 99) < rate);
                in_data  = 8'($urandom);
                flush    = ($urandom_range(0, 99) == 0);
                @(negedge CLK100MHZ);
                #1;
            end
        end
        idle(60);
        chk("final_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
